// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: buffered entry layout
// and the grant-source encoding.
package wb_arb_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dr;
    logic [XLEN-1:0]      data;
  } wb_arb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_BUF
  } wb_arb_gnt_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular buffer of completed mul/div results, with a DR-match kill that
// invalidates superseded entries and a busy mask of pending destination registers.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [REG_IDX_W-1:0] push_dr,
  input  logic [XLEN-1:0]      push_data,
  input  logic                 pop,
  input  logic                 kill_en,
  input  logic [REG_IDX_W-1:0] kill_dr,
  output wb_arb_entry_t        head,
  output logic                 empty,
  output logic                 full,
  output logic [31:0]          busy_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  wb_arb_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  assign head  = mem[head_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Slots are invalidated on pop so that valid alone marks a live pending write;
  // a push that collides with this cycle's kill is stored already dead.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].dr == kill_dr) mem[i].valid <= 1'b0;
      end
      if (pop) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= head_ptr + 1'b1;
      end
      if (push) begin
        mem[tail_ptr].valid <= !(kill_en && kill_dr == push_dr);
        mem[tail_ptr].dr    <= push_dr;
        mem[tail_ptr].data  <= push_data;
        tail_ptr            <= tail_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid) busy_mask[mem[i].dr] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between in-order writeback and buffered
// mul/div results, with a starvation guard that forces the buffer through.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 WB_REQ,
  input  logic [REG_IDX_W-1:0] WB_REQ_DR,
  input  logic [XLEN-1:0]      WB_REQ_Data,
  input  logic                 MD_V,
  input  logic [REG_IDX_W-1:0] MD_DR,
  input  logic [XLEN-1:0]      MD_Data,
  output logic                 MD_READY,
  output logic                 OUT_DE_REG_WEN,
  output logic [REG_IDX_W-1:0] OUT_DE_DR,
  output logic [XLEN-1:0]      OUT_DE_Data,
  output logic                 OUT_WB_STALL,
  output logic [31:0]          OUT_BUSY_MASK
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  wb_arb_entry_t head;
  wb_arb_gnt_e   grant;
  logic          empty, full, head_live, forced, pop, push;
  logic [31:0]   fifo_mask;
  logic [SC_W-1:0] starve_cnt;

  assign head_live = !empty && head.valid;
  assign forced    = head_live && (starve_cnt == STARVE_MAX);
  assign MD_READY  = !full && !RESET;
  // Writes to x0 are meaningless, so they are acknowledged without taking a slot.
  assign push      = MD_V && MD_READY && (MD_DR != '0);
  assign pop       = !RESET && ((grant == GNT_BUF) || (!empty && !head.valid));

  assign OUT_BUSY_MASK = RESET ? '0 : fifo_mask;
  assign OUT_WB_STALL  = !RESET && forced && WB_REQ;

  always_comb begin
    grant = GNT_NONE;
    if (!RESET) begin
      if (forced)         grant = GNT_BUF;
      else if (WB_REQ)    grant = GNT_WB;
      else if (head_live) grant = GNT_BUF;
    end
  end

  always_comb begin
    OUT_DE_REG_WEN = 1'b0;
    OUT_DE_DR      = '0;
    OUT_DE_Data    = '0;
    case (grant)
      GNT_WB: begin
        OUT_DE_REG_WEN = 1'b1;
        OUT_DE_DR      = WB_REQ_DR;
        OUT_DE_Data    = WB_REQ_Data;
      end
      GNT_BUF: begin
        OUT_DE_REG_WEN = 1'b1;
        OUT_DE_DR      = head.dr;
        OUT_DE_Data    = head.data;
      end
      default: ;
    endcase
  end

  // Counts how long a live head has been passed over; any change of head restarts it.
  always_ff @(posedge CLK) begin
    if (RESET || !head_live || grant == GNT_BUF) starve_cnt <= '0;
    else if (starve_cnt != STARVE_MAX)           starve_cnt <= starve_cnt + 1'b1;
  end

  wb_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (CLK),
    .reset     (RESET),
    .push      (push),
    .push_dr   (MD_DR),
    .push_data (MD_Data),
    .pop       (pop),
    .kill_en   (grant == GNT_WB),
    .kill_dr   (WB_REQ_DR),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .busy_mask (fifo_mask)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: a queue-based model of the arbiter predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WB_REQ = 1'b0;
  logic [4:0]  WB_REQ_DR = '0;
  logic [63:0] WB_REQ_Data = '0;
  logic        MD_V = 1'b0;
  logic [4:0]  MD_DR = '0;
  logic [63:0] MD_Data = '0;
  logic        MD_READY, OUT_DE_REG_WEN, OUT_WB_STALL;
  logic [4:0]  OUT_DE_DR;
  logic [63:0] OUT_DE_Data;
  logic [31:0] OUT_BUSY_MASK;

  typedef struct {
    logic        wen;
    logic [4:0]  dr;
    logic [63:0] data;
    logic        stall;
    logic        ready;
    logic [31:0] mask;
  } exp_t;

  typedef struct {
    bit          valid;
    logic [4:0]  dr;
    logic [63:0] data;
  } ment_t;

  exp_t  exp_q[$];
  ment_t model_q[$];
  int    starve = 0;
  bit    last_stall = 0;
  int    n_vectors = 0;
  int    n_miscompares = 0;

  logic        cur_wbr;
  logic [4:0]  cur_wdr;
  logic [63:0] cur_wdata;

  wb_port_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .WB_REQ        (WB_REQ),
    .WB_REQ_DR     (WB_REQ_DR),
    .WB_REQ_Data   (WB_REQ_Data),
    .MD_V          (MD_V),
    .MD_DR         (MD_DR),
    .MD_Data       (MD_Data),
    .MD_READY      (MD_READY),
    .OUT_DE_REG_WEN(OUT_DE_REG_WEN),
    .OUT_DE_DR     (OUT_DE_DR),
    .OUT_DE_Data   (OUT_DE_Data),
    .OUT_WB_STALL  (OUT_WB_STALL),
    .OUT_BUSY_MASK (OUT_BUSY_MASK)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vectors++;
    if (act !== req) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("wen",   64'(OUT_DE_REG_WEN), 64'(e.wen));
      checkOutput("dr",    64'(OUT_DE_DR),      64'(e.dr));
      checkOutput("data",  OUT_DE_Data,         e.data);
      checkOutput("stall", 64'(OUT_WB_STALL),   64'(e.stall));
      checkOutput("ready", 64'(MD_READY),       64'(e.ready));
      checkOutput("mask",  64'(OUT_BUSY_MASK),  64'(e.mask));
    end
  end

  // Drives one cycle of inputs and predicts the outputs from the buffer model.
  task automatic applyStimulus(input logic rst, input logic wbr, input logic [4:0] wdr,
                               input logic [63:0] wdata, input logic mv,
                               input logic [4:0] mdr, input logic [63:0] mdata);
    exp_t  e;
    ment_t n;
    bit    live, forced;
    int    gnt;
    @(posedge CLK);
    #1;
    RESET = rst; WB_REQ = wbr; WB_REQ_DR = wdr; WB_REQ_Data = wdata;
    MD_V = mv; MD_DR = mdr; MD_Data = mdata;
    e = '{wen: 1'b0, dr: 5'd0, data: 64'd0, stall: 1'b0, ready: 1'b0, mask: 32'd0};
    if (rst) begin
      model_q.delete();
      starve = 0;
    end else begin
      e.ready = (model_q.size() < DEPTH);
      foreach (model_q[i]) if (model_q[i].valid) e.mask[model_q[i].dr] = 1'b1;
      e.mask[0] = 1'b0;
      live   = (model_q.size() > 0) && model_q[0].valid;
      forced = live && (starve == STARVE_LIMIT);
      gnt    = forced ? 2 : (wbr ? 1 : (live ? 2 : 0));
      e.stall = forced && wbr;
      if (gnt == 1) begin
        e.wen = 1'b1; e.dr = wdr; e.data = wdata;
      end else if (gnt == 2) begin
        e.wen = 1'b1; e.dr = model_q[0].dr; e.data = model_q[0].data;
      end
      if (gnt == 2) begin
        model_q.delete(0);
        starve = 0;
      end else if (model_q.size() > 0 && !model_q[0].valid) begin
        model_q.delete(0);
        starve = 0;
      end else if (live) begin
        if (starve < STARVE_LIMIT) starve++;
      end else begin
        starve = 0;
      end
      if (gnt == 1) foreach (model_q[i]) if (model_q[i].dr == wdr) model_q[i].valid = 0;
      if (mv && e.ready && mdr != 5'd0) begin
        n.valid = !(gnt == 1 && mdr == wdr);
        n.dr    = mdr;
        n.data  = mdata;
        model_q.push_back(n);
      end
    end
    last_stall = e.stall;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    // Reset held with a pending mul/div request that must be ignored.
    applyStimulus(1, 0, 5'd0, 64'd0, 1, 5'd5, 64'h55);
    applyStimulus(1, 0, 5'd0, 64'd0, 1, 5'd5, 64'h55);
    idle(3);
    // Single buffered result written the following cycle.
    applyStimulus(0, 0, 5'd0, 64'd0, 1, 5'd5, 64'h1234);
    idle(3);
    // Continuous writeback starves the buffer until the forced grant.
    applyStimulus(0, 1, 5'd3, 64'h33, 1, 5'd7, 64'h77);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 5'd3, 64'h33, 0, 5'd0, 64'd0);
    idle(2);
    // A newer writeback to the same register kills the buffered value.
    applyStimulus(0, 1, 5'd2, 64'h22, 1, 5'd9, 64'hA);
    applyStimulus(0, 1, 5'd9, 64'hB, 0, 5'd0, 64'd0);
    idle(3);
    // Fill the buffer under writeback pressure, then an x0 push.
    applyStimulus(0, 1, 5'd4, 64'h44, 1, 5'd10, 64'h100);
    applyStimulus(0, 1, 5'd4, 64'h44, 1, 5'd11, 64'h110);
    applyStimulus(0, 1, 5'd4, 64'h44, 1, 5'd12, 64'h120);
    idle(6);
    applyStimulus(0, 0, 5'd0, 64'd0, 1, 5'd0, 64'hDEAD);
    idle(2);
    // Reset pulse with two entries buffered.
    applyStimulus(0, 1, 5'd6, 64'h66, 1, 5'd13, 64'h130);
    applyStimulus(0, 1, 5'd6, 64'h66, 1, 5'd14, 64'h140);
    applyStimulus(1, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    idle(3);
    // Random traffic; writeback holds its request while stalled.
    cur_wbr = 0; cur_wdr = '0; cur_wdata = '0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        cur_wbr   = ($urandom_range(0, 1) == 1);
        cur_wdr   = 5'($urandom_range(0, 7));
        cur_wdata = {$urandom, $urandom};
      end
      applyStimulus(($urandom_range(0, 49) == 0), cur_wbr, cur_wdr, cur_wdata,
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                    {$urandom, $urandom});
    end
    idle(4);
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_miscompares++;
      $display("[TB] FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
